// File: rtl/wb_stream_capture.sv
// Captures a block of 128-bit stream beats into RAM on command and serves them over Wishbone.
// Optional build macro CAPTURE_TRIGGER_EN gates the capture start on a signed sample threshold.
module wb_stream_capture #(
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned ADDR_W     = 22
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              wb_cyc_i,
  input  logic              wb_stb_i,
  input  logic              wb_we_i,
  input  logic [ADDR_W-1:0] wb_adr_i,
  input  logic [31:0]       wb_dat_i,
  input  logic [3:0]        wb_sel_i,
  output logic [31:0]       wb_dat_o,
  output logic              wb_ack_o,
  output logic              wb_err_o,
  output logic              wb_rty_o,
  input  logic [127:0]      s_tdata,
  input  logic              s_tvalid,
  output logic              s_tready
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned CNT_W = DEPTH_LOG2 + 1;
  localparam logic [31:0] ID_VAL = 32'h4341_5030;
`ifdef CAPTURE_TRIGGER_EN
  localparam logic TRIG_BUILD = 1'b1;
`else
  localparam logic TRIG_BUILD = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, CAPTURE = 2'd2, DONE = 2'd3} state_t;

  state_t                  state;
  logic [CNT_W-1:0]        count;
  logic [11:0]             thresh;
  logic                    pend;
  logic                    rd_win;
  logic [1:0]              rd_sel;
  logic [127:0]            ram_q;
  logic [127:0]            mem [DEPTH];

  logic                    acc_c, reg_wr_c, arm_c, abort_c, trig_c;
  logic                    start_c, cap_c, mem_we_c;
  logic [DEPTH_LOG2-1:0]   mem_waddr_c;
  logic [DEPTH_LOG2-1:0]   rd_beat_c;
  logic [31:0]             rd_data_c;
  logic                    unused_c;

  assign wb_err_o = 1'b0;
  assign wb_rty_o = 1'b0;
  assign unused_c = ^{wb_sel_i, wb_adr_i[ADDR_W-2:DEPTH_LOG2+4], wb_adr_i[1:0], wb_dat_i[31:12]};

  // Access decode and capture write strobes
  always_comb begin
    acc_c       = wb_cyc_i & wb_stb_i & ~wb_ack_o & ~pend;
    reg_wr_c    = acc_c & wb_we_i & ~wb_adr_i[ADDR_W-1];
    arm_c       = reg_wr_c & (wb_adr_i[3:2] == 2'd1) & wb_dat_i[0];
    abort_c     = reg_wr_c & (wb_adr_i[3:2] == 2'd1) & wb_dat_i[1];
    rd_beat_c   = wb_adr_i[DEPTH_LOG2+3:4];
`ifdef CAPTURE_TRIGGER_EN
    trig_c = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if ($signed(s_tdata[16*i+4 +: 12]) > $signed(thresh)) trig_c = 1'b1;
    end
`else
    trig_c = 1'b1;
`endif
    start_c     = (state == ARMED) & s_tvalid & trig_c & ~abort_c;
    cap_c       = (state == CAPTURE) & s_tvalid & ~abort_c;
    mem_we_c    = start_c | cap_c;
    mem_waddr_c = start_c ? '0 : count[DEPTH_LOG2-1:0];
  end

  // Capture FSM; abort beats arm, arm only honoured when not mid-capture
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state <= IDLE;
      count <= '0;
    end else if (abort_c) begin
      state <= IDLE;
    end else if (arm_c && (state == IDLE || state == DONE)) begin
      state <= ARMED;
      count <= '0;
    end else if (start_c) begin
      state <= CAPTURE;
      count <= CNT_W'(1);
    end else if (cap_c) begin
      count <= count + CNT_W'(1);
      if (count == CNT_W'(DEPTH - 1)) state <= DONE;
    end
  end

  // Capture RAM: one write port from the stream, one synchronous read port for Wishbone
  always_ff @(posedge wb_clk_i) begin
    if (mem_we_c) mem[mem_waddr_c] <= s_tdata;
    if (acc_c)    ram_q <= mem[rd_beat_c];
  end

  always_comb begin
    rd_data_c = '0;
    if (rd_win) begin
      rd_data_c = ram_q[32*rd_sel +: 32];
    end else begin
      case (rd_sel)
        2'd0:    rd_data_c = ID_VAL;
        2'd1:    rd_data_c = {27'd0, TRIG_BUILD, 2'b00, state};
        2'd2:    rd_data_c = 32'(thresh);
        default: rd_data_c = 32'(count);
      endcase
    end
  end

  // Wishbone: sample, RAM/register fetch, then registered ack two cycles after strobe
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      s_tready <= 1'b0;
      pend     <= 1'b0;
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
      rd_win   <= 1'b0;
      rd_sel   <= '0;
      thresh   <= '0;
    end else begin
      s_tready <= 1'b1;
      pend     <= acc_c;
      wb_ack_o <= pend & wb_cyc_i;
      if (acc_c) begin
        rd_win <= wb_adr_i[ADDR_W-1];
        rd_sel <= wb_adr_i[3:2];
      end
      if (reg_wr_c && wb_adr_i[3:2] == 2'd2) thresh <= wb_dat_i[11:0];
      if (pend) wb_dat_o <= rd_data_c;
    end
  end

endmodule
